// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer with pedestrian WALK insertion.
// Tick-driven phase timer; lamps are a Moore decode of the registered state.
module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_btn,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk_light,
    output logic       stop_light,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_END    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] W_END    = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             after_ns;
    logic             ns_exit;
    logic             ew_exit;

    // A green yields early only when its own approach is empty; otherwise it runs to GREEN_MAX.
    assign ns_exit = tick && (car_ew || ped_pending) &&
                     ((cnt >= GMIN_END && !car_ns) || cnt >= GMAX_END);
    assign ew_exit = tick && (car_ns || ped_pending) &&
                     ((cnt >= GMIN_END && !car_ew) || cnt >= GMAX_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= NS_G;
            cnt         <= '0;
            ped_pending <= 1'b0;
            after_ns    <= 1'b0;
        end else begin
            if (ped_btn && state != WALK)
                ped_pending <= 1'b1;
            if (tick && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            // Transitions below override the count and, on entry to WALK, the pending set.
            case (state)
                NS_G: if (ns_exit) begin
                    state <= NS_Y;
                    cnt   <= '0;
                end
                NS_Y: if (tick && cnt == Y_END) begin
                    state <= AR1;
                    cnt   <= '0;
                end
                AR1: if (tick && cnt == AR_END) begin
                    cnt <= '0;
                    if (ped_pending) begin
                        state       <= WALK;
                        after_ns    <= 1'b0;
                        ped_pending <= 1'b0;
                    end else begin
                        state <= EW_G;
                    end
                end
                EW_G: if (ew_exit) begin
                    state <= EW_Y;
                    cnt   <= '0;
                end
                EW_Y: if (tick && cnt == Y_END) begin
                    state <= AR2;
                    cnt   <= '0;
                end
                AR2: if (tick && cnt == AR_END) begin
                    cnt <= '0;
                    if (ped_pending) begin
                        state       <= WALK;
                        after_ns    <= 1'b1;
                        ped_pending <= 1'b0;
                    end else begin
                        state <= NS_G;
                    end
                end
                WALK: if (tick && cnt == W_END) begin
                    state <= after_ns ? NS_G : EW_G;
                    cnt   <= '0;
                end
                default: begin
                    state <= NS_G;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign phase = state;

    always_comb begin
        ns_red     = 1'b1;
        ns_yellow  = 1'b0;
        ns_green   = 1'b0;
        ew_red     = 1'b1;
        ew_yellow  = 1'b0;
        ew_green   = 1'b0;
        walk_light = 1'b0;
        case (state)
            NS_G: begin ns_red = 1'b0; ns_green  = 1'b1; end
            NS_Y: begin ns_red = 1'b0; ns_yellow = 1'b1; end
            EW_G: begin ew_red = 1'b0; ew_green  = 1'b1; end
            EW_Y: begin ew_red = 1'b0; ew_yellow = 1'b1; end
            WALK: walk_light = 1'b1;
            default: ;
        endcase
    end

    assign stop_light = ~walk_light;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: driver queues hand-computed phase/pending per clock edge,
// a negedge monitor pops and checks phase, all lamps and ped_pending.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, car_ns = 1'b0, car_ew = 1'b0, ped_btn = 1'b0;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic       walk_light, stop_light, ped_pending;
    logic [2:0] phase;

    intersection_phase_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .car_ns(car_ns), .car_ew(car_ew),
        .ped_btn(ped_btn), .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk_light(walk_light), .stop_light(stop_light), .ped_pending(ped_pending),
        .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, stop}
    function automatic logic [7:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 8'b001_100_01;
            3'd1:    return 8'b010_100_01;
            3'd3:    return 8'b100_001_01;
            3'd4:    return 8'b100_010_01;
            3'd6:    return 8'b100_100_10;
            default: return 8'b100_100_01;
        endcase
    endfunction

    task automatic check_now(input string name, input logic [2:0] ph, input logic pend);
        logic [7:0] act;
        act = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk_light, stop_light};
        checks += 3;
        if (phase !== ph) begin
            errors++;
            $display("FAIL %s cyc=%0d phase: got %0d want %0d", name, cyc, phase, ph);
        end
        if (act !== lamps_for(ph)) begin
            errors++;
            $display("FAIL %s cyc=%0d lamps: got %b want %b", name, cyc, act, lamps_for(ph));
        end
        if (ped_pending !== pend) begin
            errors++;
            $display("FAIL %s cyc=%0d ped_pending: got %b want %b", name, cyc, ped_pending, pend);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_now("sb", e.ph, e.pend);
            end
        end
    end

    task automatic run(input logic t, input logic cn, input logic ce, input logic pb,
                       input logic [2:0] ph, input logic pend, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            rst = 1'b1; tick = t; car_ns = cn; car_ew = ce; ped_btn = pb;
            @(posedge clk); #1;
            q.push_back('{ph: ph, pend: pend});
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b0; tick = 1'b0; car_ns = 1'b0; car_ew = 1'b0; ped_btn = 1'b0;
        @(posedge clk); #1;
        q.push_back('{ph: 3'd0, pend: 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held for two edges, then idle with ticks: green stays on NS
        do_reset();
        do_reset();
        run(1, 0, 0, 0, 3'd0, 0, 50);

        // EW demand only: min green, yellow, all-red, then EW holds
        do_reset();
        run(1, 0, 1, 0, 3'd0, 0, 3);
        run(1, 0, 1, 0, 3'd1, 0, 2);
        run(1, 0, 1, 0, 3'd2, 0, 1);
        run(1, 0, 1, 0, 3'd3, 0, 6);

        // both roads busy: each green runs to GREEN_MAX
        do_reset();
        run(1, 1, 1, 0, 3'd0, 0, 9);
        run(1, 1, 1, 0, 3'd1, 0, 2);
        run(1, 1, 1, 0, 3'd2, 0, 1);
        run(1, 1, 1, 0, 3'd3, 0, 10);
        run(1, 1, 1, 0, 3'd4, 0, 2);
        run(1, 1, 1, 0, 3'd5, 0, 1);
        run(1, 1, 1, 0, 3'd0, 0, 2);

        // pedestrian from NS side -> WALK -> EW_G, then from EW side -> WALK -> NS_G
        do_reset();
        run(1, 0, 0, 0, 3'd0, 0, 2);
        run(1, 0, 0, 1, 3'd0, 1, 1);
        run(1, 0, 0, 0, 3'd1, 1, 2);
        run(1, 0, 0, 0, 3'd2, 1, 1);
        run(1, 0, 0, 0, 3'd6, 0, 1);
        run(1, 0, 0, 1, 3'd6, 0, 2);
        run(1, 0, 0, 0, 3'd6, 0, 2);
        run(1, 0, 0, 0, 3'd3, 0, 3);
        run(1, 0, 0, 1, 3'd3, 1, 1);
        run(1, 0, 0, 0, 3'd4, 1, 2);
        run(1, 0, 0, 0, 3'd5, 1, 1);
        run(1, 0, 0, 0, 3'd6, 0, 5);
        run(1, 0, 0, 0, 3'd0, 0, 3);

        // asynchronous reset in the middle of WALK
        do_reset();
        run(1, 0, 0, 1, 3'd0, 1, 1);
        run(1, 0, 0, 0, 3'd0, 1, 2);
        run(1, 0, 0, 0, 3'd1, 1, 2);
        run(1, 0, 0, 0, 3'd2, 1, 1);
        run(1, 0, 0, 0, 3'd6, 0, 2);
        @(negedge clk); #3;
        rst = 1'b0;
        #1;
        check_now("async_rst", 3'd0, 1'b0);

        // tick gaps freeze both phase and timer
        run(1, 0, 1, 0, 3'd0, 0, 2);
        run(0, 0, 1, 0, 3'd0, 0, 20);
        run(1, 0, 1, 0, 3'd0, 0, 1);
        run(1, 0, 1, 0, 3'd1, 0, 1);
        run(0, 0, 1, 0, 3'd1, 0, 5);
        run(1, 0, 1, 0, 3'd1, 0, 1);
        run(0, 0, 1, 0, 3'd1, 0, 5);
        run(1, 0, 1, 0, 3'd2, 0, 1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
